stopwatch_module: RTL and testbench

- Free-running elapsed-time counter for the board top level. Driven by a 3-bit command bus (start / clear / stop).
- A prescaler derives a tick from clk. While the stopwatch is running, each tick increments a 32-bit count.
- The count feeds the display/BCD formatting logic downstream.

---
 rtl/stopwatch_pkg.sv | 18 +
 rtl/stopwatch_module_tick_prescaler.sv | 28 ++
 rtl/stopwatch_module.sv | 71 +++++++
 tb/tb_stopwatch_module.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants and types for the stopwatch: command bit positions,
// default count width and the IDLE/RUN state encoding.
package stopwatch_pkg;

   localparam int unsigned CTRL_START = 0;
   localparam int unsigned CTRL_CLEAR = 1;
   localparam int unsigned CTRL_STOP  = 2;
   localparam int unsigned CTRL_W     = 3;

   localparam int unsigned COUNT_W = 32;

   // The state bit is the running flag itself.
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/stopwatch_module_tick_prescaler.sv
// Divides clk by TICK_DIV while enabled; tick is a combinational pulse on
// the edge where the divider wraps, so the consumer increments on that edge.
module tick_prescaler #(
   parameter int unsigned TICK_DIV = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [PW-1:0] cnt;

   assign tick = en && (cnt == PW'(TICK_DIV - 1));

   // Holds its partial value while disabled so a resume keeps the phase.
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + PW'(1);
      end
   end

endmodule

// File: rtl/stopwatch_module.sv
// Elapsed-time counter: IDLE/RUN FSM driven by level commands
// (clear > stop > start), prescaled tick, wrapping count with sticky overflow.
module stopwatch_module
   import stopwatch_pkg::*;
#(
   parameter int unsigned TICK_DIV = 1,
   parameter int unsigned COUNT_W  = stopwatch_pkg::COUNT_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [CTRL_W-1:0]  control,
   output logic [COUNT_W-1:0] count,
   output logic               running,
   output logic               overflow
);

   state_t state;
   state_t state_next;
   logic   tick;
   logic   clear;
   logic   stop;
   logic   start;

   assign clear = control[CTRL_CLEAR];
   assign stop  = control[CTRL_STOP];
   assign start = control[CTRL_START];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (clear || stop) begin
         state_next = IDLE;
      end else if (start) begin
         state_next = RUN;
      end
   end

   assign running = (state == RUN);

   // Enable is the pre-edge running value, so a stop edge still counts
   // and a start edge does not.
   tick_prescaler #(
      .TICK_DIV(TICK_DIV)
   ) u_prescaler (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (running),
      .clr  (clear),
      .tick (tick)
   );

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         count    <= '0;
         overflow <= 1'b0;
      end else if (tick) begin
         count <= count + COUNT_W'(1);
         if (count == '1) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_stopwatch_module.sv
// Directed bench: table-driven command/expectation vectors on a TICK_DIV=1
// instance, plus sequences for prescaler phase retention and 8-bit wrap.
module tb_stopwatch_module;

   typedef struct {
      logic        rst_n;
      logic [2:0]  ctrl;
      logic [31:0] cnt;
      logic        run;
      logic        ovf;
   } vec_t;

   logic        clk = 1'b0;
   logic        r1 = 1'b0, r4 = 1'b0, r8 = 1'b0;
   logic [2:0]  c1 = 3'b000, c4 = 3'b000, c8 = 3'b000;
   logic [31:0] cnt1, cnt4;
   logic [7:0]  cnt8;
   logic        run1, run4, run8;
   logic        ovf1, ovf4, ovf8;

   int n_cmp = 0;
   int n_err = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   stopwatch_module #(.TICK_DIV(1), .COUNT_W(32)) u_div1 (
      .clk(clk), .rst_n(r1), .control(c1),
      .count(cnt1), .running(run1), .overflow(ovf1)
   );

   stopwatch_module #(.TICK_DIV(4), .COUNT_W(32)) u_div4 (
      .clk(clk), .rst_n(r4), .control(c4),
      .count(cnt4), .running(run4), .overflow(ovf4)
   );

   stopwatch_module #(.TICK_DIV(1), .COUNT_W(8)) u_w8 (
      .clk(clk), .rst_n(r8), .control(c8),
      .count(cnt8), .running(run8), .overflow(ovf8)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input int n, input logic rst_n, input logic [2:0] ctrl,
                      input int cnt0, input int cnt_step, input logic run, input logic ovf);
      for (int i = 0; i < n; i++) begin
         vec_t v;
         v.rst_n = rst_n;
         v.ctrl  = ctrl;
         v.cnt   = 32'(cnt0 + i * cnt_step);
         v.run   = run;
         v.ovf   = ovf;
         vecs.push_back(v);
      end
   endtask

   task automatic edge_wait();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // ---------------- table-driven, TICK_DIV = 1 ----------------
      add(2,  1'b0, 3'b111, 0, 0, 1'b0, 1'b0);   // reset overrides all commands
      add(10, 1'b1, 3'b001, 0, 1, 1'b1, 1'b0);   // count 0..9, running
      add(2,  1'b1, 3'b100, 10, 0, 1'b0, 1'b0);  // stop edge increments to 10, holds
      add(2,  1'b1, 3'b010, 0, 0, 1'b0, 1'b0);   // clear
      add(10, 1'b1, 3'b001, 0, 1, 1'b1, 1'b0);   // restart 0..9
      add(4,  1'b1, 3'b000, 10, 1, 1'b1, 1'b0);  // keeps running to 13
      add(1,  1'b1, 3'b011, 0, 0, 1'b0, 1'b0);   // clear beats start
      add(1,  1'b1, 3'b001, 0, 0, 1'b1, 1'b0);   // start edge: no increment
      add(2,  1'b1, 3'b000, 1, 1, 1'b1, 1'b0);
      add(1,  1'b1, 3'b101, 3, 0, 1'b0, 1'b0);   // stop beats start, final increment
      add(2,  1'b1, 3'b000, 3, 0, 1'b0, 1'b0);   // held while stopped
      add(1,  1'b1, 3'b100, 3, 0, 1'b0, 1'b0);   // stop while stopped: no effect

      for (int i = 0; i < vecs.size(); i++) begin
         r1 = vecs[i].rst_n;
         c1 = vecs[i].ctrl;
         edge_wait();
         chk($sformatf("v%0d_count", i),   cnt1, vecs[i].cnt);
         chk($sformatf("v%0d_running", i), 32'(run1), 32'(vecs[i].run));
         chk($sformatf("v%0d_overflow", i), 32'(ovf1), 32'(vecs[i].ovf));
      end

      // ---------------- prescaler, TICK_DIV = 4 ----------------
      r4 = 1'b0; c4 = 3'b000;
      edge_wait();
      chk("div4_reset_count", cnt4, 0);
      r4 = 1'b1; c4 = 3'b001;
      edge_wait();
      chk("div4_start_running", 32'(run4), 1);
      chk("div4_start_count", cnt4, 0);
      c4 = 3'b000;
      for (int i = 1; i <= 20; i++) begin
         edge_wait();
         chk($sformatf("div4_run%0d", i), cnt4, 32'(i / 4));
      end
      repeat (2) edge_wait();                     // prescaler phase now 2
      chk("div4_mid_count", cnt4, 5);
      c4 = 3'b100;
      edge_wait();                                // phase advances to 3, no tick
      chk("div4_stop_count", cnt4, 5);
      chk("div4_stop_running", 32'(run4), 0);
      c4 = 3'b000;
      repeat (3) edge_wait();
      chk("div4_hold_count", cnt4, 5);
      c4 = 3'b001;
      edge_wait();
      chk("div4_resume_count", cnt4, 5);
      c4 = 3'b000;
      edge_wait();                                // retained phase 3 ticks at once
      chk("div4_resume_tick", cnt4, 6);
      repeat (3) edge_wait();
      chk("div4_resume_plus3", cnt4, 6);
      edge_wait();
      chk("div4_resume_plus4", cnt4, 7);

      // ---------------- wrap, COUNT_W = 8 ----------------
      r8 = 1'b0; c8 = 3'b111;
      edge_wait();
      chk("w8_reset_ovf", 32'(ovf8), 0);
      r8 = 1'b1; c8 = 3'b001;
      edge_wait();
      c8 = 3'b000;
      repeat (255) edge_wait();
      chk("w8_count_max", 32'(cnt8), 255);
      chk("w8_ovf_before_wrap", 32'(ovf8), 0);
      edge_wait();
      chk("w8_wrap_count", 32'(cnt8), 0);
      chk("w8_wrap_ovf", 32'(ovf8), 1);
      chk("w8_wrap_running", 32'(run8), 1);
      edge_wait();
      chk("w8_after_wrap_count", 32'(cnt8), 1);
      c8 = 3'b100;
      edge_wait();
      c8 = 3'b000;
      repeat (3) edge_wait();
      chk("w8_ovf_sticky", 32'(ovf8), 1);
      chk("w8_stopped_count", 32'(cnt8), 2);
      c8 = 3'b001;
      edge_wait();
      chk("w8_ovf_after_start", 32'(ovf8), 1);
      c8 = 3'b010;
      edge_wait();
      chk("w8_clear_ovf", 32'(ovf8), 0);
      chk("w8_clear_count", 32'(cnt8), 0);
      chk("w8_clear_running", 32'(run8), 0);
      c8 = 3'b000;
      repeat (2) edge_wait();
      chk("w8_idle_after_clear", 32'(cnt8), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
